gcd_job_ctrl: RTL and testbench
===============================

# gcd_job_ctrl

Control/status block that sequences one GCD computation at a time. Software on the AXI side drives it through a 64-bit SRAM-style register port, the same port style the AXI-to-SRAM bridge produces. It issues a one-cycle start pulse to the GCD core, times the run, detects completion or timeout, and raises an interrupt. It sits beside the argument/result unpacker, on a second SRAM-style decode window.

## Interface
Parameters:
- CNT_W, 32, width of cycle counter and timeout limit (≤ 32)
- TIMEOUT_RST, 32'h000F_FFFF, reset value of TIMEOUT_LIMIT; 0 disables the timeout

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RESETn  in  1  asynchronous active-low reset
- SRAM_CEn  in  1  access strobe, active low
- SRAM_ADDR  in  32  byte address; only [4:3] are decoded
- SRAM_WDATA  in  64  write data
- SRAM_WEn  in  1  0 = write, 1 = read
- SRAM_WBEn  in  8  active-low byte enables (writes only)
- SRAM_RDATA  out  64  read data, registered
- GCD_START  out  1  one-cycle launch pulse to the GCD core
- GCD_ABORT  out  1  one-cycle abort pulse (abort request or timeout)
- GCD_DONE  in  1  level completion flag from the GCD core
- IRQ  out  1  level interrupt = IRQ_EN & (DONE_F | TO_F)

## Operation
Register map (ADDR[4:3]):
- 0 CTRL: bit0 START (W1, self-clearing); bit1 IRQ_EN (RW); bit2 ABORT (W1, self-clearing). Read returns {61'b0, 0, IRQ_EN, 0}.
- 1 STATUS: bit0 BUSY (RO); bit1 DONE_F (sticky, W1C); bit2 TO_F (sticky, W1C). Other bits read 0.
- 2 CYCLES: RO; cycle count latched at the last DONE or timeout, zero-extended.
- 3 TIMEOUT_LIMIT: RW, lower CNT_W bits.
- Byte enables apply per byte. A W1 or W1C bit acts only if its byte lane is enabled.

FSM states: IDLE, LAUNCH, RUN, FINISH.
- IDLE: START write → LAUNCH. At the same time, clear DONE_F and TO_F and zero the counter.
- LAUNCH (1 cycle): GCD_START=1 → RUN.
- RUN: counter increments every cycle, saturating at all-ones.
  - A rising edge of GCD_DONE (registered previous value 0, current 1) → FINISH.
  - Otherwise, if limit≠0 and counter==limit-1 → IDLE, with the following in the same transition: GCD_ABORT=1 for 1 cycle, TO_F=1, CYCLES=limit.
  - Otherwise, an ABORT write → IDLE with GCD_ABORT=1 for 1 cycle. No flag is set and CYCLES is unchanged.
- FINISH (1 cycle): CYCLES ← counter, DONE_F=1 → IDLE.
- BUSY = (state ≠ IDLE).
- Priority in the same RUN cycle: DONE edge > timeout > ABORT.
- START write while BUSY is ignored. ABORT write in IDLE is ignored.
- GCD_DONE is ignored outside RUN. Its edge register still updates every cycle, so a DONE left high from a previous job is not a new completion.
- A W1C of a flag in the same cycle the FSM sets it: the set wins.

## Timing
- Reset values: SRAM_RDATA=0, GCD_START=0, GCD_ABORT=0, IRQ=0, state=IDLE, IRQ_EN=0, flags=0, CYCLES=0, TIMEOUT_LIMIT=TIMEOUT_RST, done-edge register=0.
- Reads: SRAM_RDATA is valid the cycle after CEn=0 with WEn=1. It holds its value until the next read.
- Writes take effect at the sampling edge, with zero wait states.
- START is written in cycle T. GCD_START is high in T+1. RUN begins at T+2.
- If the DONE edge is sampled with counter value N, then CYCLES=N, DONE_F=1 one cycle later, and IRQ rises the cycle after that.
- IRQ is registered and follows flag or enable changes with 1 cycle latency.
- Reset asserted mid-run forces all outputs to their reset values immediately, with no ABORT pulse.

## Test plan
- Reset, then read all 4 registers → CTRL=0, STATUS=0, CYCLES=0, LIMIT=0x000F_FFFF.
- Write IRQ_EN=1 and START, drive a GCD_DONE rising edge 10 cycles into RUN → exactly one GCD_START pulse, then STATUS=0b010, CYCLES=10, IRQ=1. W1C DONE_F → IRQ=0.
- Set LIMIT=5, START, hold DONE low → GCD_ABORT pulses once, STATUS=0b100, CYCLES=5, BUSY=0.
- START, then at RUN cycle 3 write START again, then ABORT → second START ignored, one GCD_ABORT pulse, STATUS=0, CYCLES unchanged.
- Set LIMIT=4 and raise the DONE edge in the same cycle the timeout fires → DONE_F=1, TO_F=0, no GCD_ABORT.
- Leave DONE high across a new START, then deassert RESETn mid-RUN → no false completion while DONE stays high; on reset, all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/gcd_job_ctrl.sv
// Job sequencer for a single GCD core: register window, launch/abort pulses,
// run timer with timeout, sticky completion flags and a level interrupt.
//
// state  | meaning
// IDLE   | no job active, waiting for a START write
// LAUNCH | one cycle, GCD_START asserted
// RUN    | core working, counter running, watching DONE edge / timeout / ABORT
// FINISH | one cycle, latch CYCLES and set DONE_F
module gcd_job_ctrl #(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] TIMEOUT_RST = 32'h000F_FFFF
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        SRAM_CEn,
  input  logic [31:0] SRAM_ADDR,
  input  logic [63:0] SRAM_WDATA,
  input  logic        SRAM_WEn,
  input  logic [7:0]  SRAM_WBEn,
  output logic [63:0] SRAM_RDATA,
  output logic        GCD_START,
  output logic        GCD_ABORT,
  input  logic        GCD_DONE,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cycles_q, limit_q;
  logic               irq_en_q, done_f_q, to_f_q, done_q, abort_q;
  logic               wr, rd, lane0, start_wr, abort_wr, w1c_done, w1c_to;
  logic               done_rise, timeout_hit, done_set, to_set, abort_d;
  logic [63:0]        limit_merge;
  logic               unused_bits;

  assign wr        = !SRAM_CEn && !SRAM_WEn;
  assign rd        = !SRAM_CEn && SRAM_WEn;
  assign lane0     = !SRAM_WBEn[0];
  assign start_wr  = wr && lane0 && (SRAM_ADDR[4:3] == 2'd0) && SRAM_WDATA[0];
  assign abort_wr  = wr && lane0 && (SRAM_ADDR[4:3] == 2'd0) && SRAM_WDATA[2];
  assign w1c_done  = wr && lane0 && (SRAM_ADDR[4:3] == 2'd1) && SRAM_WDATA[1];
  assign w1c_to    = wr && lane0 && (SRAM_ADDR[4:3] == 2'd1) && SRAM_WDATA[2];

  // A DONE level carried over from an earlier job is not a new completion.
  assign done_rise   = GCD_DONE && !done_q;
  assign timeout_hit = (limit_q != '0) && (cnt_q == limit_q - CNT_ONE);

  assign unused_bits = ^{SRAM_ADDR[31:5], SRAM_ADDR[2:0], limit_merge[63:CNT_W]};

  always_comb begin
    limit_merge = 64'(limit_q);
    for (int b = 0; b < 8; b++) begin
      if (!SRAM_WBEn[b]) limit_merge[8*b +: 8] = SRAM_WDATA[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    abort_d  = 1'b0;
    to_set   = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE:   if (start_wr) state_d = LAUNCH;
      LAUNCH: state_d = RUN;
      RUN: begin
        if (done_rise) begin
          state_d = FINISH;
        end else if (timeout_hit) begin
          state_d = IDLE;
          abort_d = 1'b1;
          to_set  = 1'b1;
        end else if (abort_wr) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      FINISH: begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign GCD_START = (state_q == LAUNCH);
  assign GCD_ABORT = abort_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cycles_q   <= '0;
      limit_q    <= TIMEOUT_RST[CNT_W-1:0];
      irq_en_q   <= 1'b0;
      done_f_q   <= 1'b0;
      to_f_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      IRQ        <= 1'b0;
      SRAM_RDATA <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= GCD_DONE;
      abort_q <= abort_d;
      IRQ     <= irq_en_q && (done_f_q || to_f_q);

      if (state_q == IDLE && start_wr) begin
        cnt_q <= '0;
      end else if (state_q == RUN && !done_rise && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      if (done_set)    cycles_q <= cnt_q;
      else if (to_set) cycles_q <= limit_q;

      // FSM-driven sets come after the W1C clears so the set wins.
      if (state_q == IDLE && start_wr) begin
        done_f_q <= 1'b0;
        to_f_q   <= 1'b0;
      end else begin
        if (w1c_done) done_f_q <= 1'b0;
        if (w1c_to)   to_f_q   <= 1'b0;
        if (done_set) done_f_q <= 1'b1;
        if (to_set)   to_f_q   <= 1'b1;
      end

      if (wr && lane0 && SRAM_ADDR[4:3] == 2'd0) irq_en_q <= SRAM_WDATA[1];
      if (wr && SRAM_ADDR[4:3] == 2'd3)         limit_q  <= limit_merge[CNT_W-1:0];

      if (rd) begin
        case (SRAM_ADDR[4:3])
          2'd0:    SRAM_RDATA <= {61'b0, 1'b0, irq_en_q, 1'b0};
          2'd1:    SRAM_RDATA <= {61'b0, to_f_q, done_f_q, state_q != IDLE};
          2'd2:    SRAM_RDATA <= 64'(cycles_q);
          default: SRAM_RDATA <= 64'(limit_q);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Directed bench for gcd_job_ctrl: register vector table plus hand-timed job
// sequences (completion, timeout, abort, DONE/timeout collision, mid-run reset).
module tb_gcd_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        wen = 1'b1;
  logic [7:0]  wben = 8'hFF;
  logic [63:0] rdata;
  logic        gcd_start, gcd_abort, gcd_done, irq;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_abort = 0;

  gcd_job_ctrl #(.CNT_W(32), .TIMEOUT_RST(32'h000F_FFFF)) dut (
    .CLK(clk), .RESETn(rst_n), .SRAM_CEn(cen), .SRAM_ADDR(addr),
    .SRAM_WDATA(wdata), .SRAM_WEn(wen), .SRAM_WBEn(wben), .SRAM_RDATA(rdata),
    .GCD_START(gcd_start), .GCD_ABORT(gcd_abort), .GCD_DONE(gcd_done), .IRQ(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gcd_start) n_start++;
    if (gcd_abort) n_abort++;
  end

  typedef struct {
    bit          wr;
    logic [1:0]  rsel;
    logic [63:0] wd;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [1:0] rsel, input logic [63:0] d, input logic [7:0] be);
    cen = 1'b0; wen = 1'b0; addr = {27'h8, rsel, 3'b101}; wdata = d; wben = be;
    @(negedge clk);
    cen = 1'b1; wen = 1'b1; wben = 8'hFF;
  endtask

  task automatic reg_rd(input logic [1:0] rsel, output logic [63:0] d);
    cen = 1'b0; wen = 1'b1; addr = {27'h8, rsel, 3'b000};
    @(negedge clk);
    cen = 1'b1;
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    gcd_done = 1'b0;

    vecs[0]  = '{1'b0, 2'd0, 64'h0, 8'hFF, 64'h0};
    vecs[1]  = '{1'b0, 2'd1, 64'h0, 8'hFF, 64'h0};
    vecs[2]  = '{1'b0, 2'd2, 64'h0, 8'hFF, 64'h0};
    vecs[3]  = '{1'b0, 2'd3, 64'h0, 8'hFF, 64'h000F_FFFF};
    vecs[4]  = '{1'b1, 2'd3, 64'h1234_5678, 8'h00, 64'h0};
    vecs[5]  = '{1'b0, 2'd3, 64'h0, 8'hFF, 64'h1234_5678};
    vecs[6]  = '{1'b1, 2'd3, 64'hAABB_CCDD, 8'hF5, 64'h0};
    vecs[7]  = '{1'b0, 2'd3, 64'h0, 8'hFF, 64'hAA34_CC78};
    vecs[8]  = '{1'b1, 2'd3, 64'hFFFF_FFFF_0000_0000, 8'h0F, 64'h0};
    vecs[9]  = '{1'b0, 2'd3, 64'h0, 8'hFF, 64'hAA34_CC78};
    vecs[10] = '{1'b1, 2'd0, 64'h2, 8'hFF, 64'h0};
    vecs[11] = '{1'b0, 2'd0, 64'h0, 8'hFF, 64'h0};
    vecs[12] = '{1'b1, 2'd0, 64'h2, 8'hFE, 64'h0};
    vecs[13] = '{1'b0, 2'd0, 64'h0, 8'hFF, 64'h2};
    vecs[14] = '{1'b1, 2'd0, 64'h1, 8'h01, 64'h0};
    vecs[15] = '{1'b0, 2'd1, 64'h0, 8'hFF, 64'h0};

    idle(2);
    check("rst_rdata", rdata, 64'h0);
    check("rst_start", 64'(gcd_start), 64'h0);
    check("rst_abort", 64'(gcd_abort), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        reg_wr(vecs[i].rsel, vecs[i].wd, vecs[i].be);
      end else begin
        reg_rd(vecs[i].rsel, d);
        check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
      end
    end
    check("no_start_lane_off", 64'(n_start), 64'h0);

    // Completion: DONE edge sampled with counter 10.
    reg_wr(2'd3, 64'd0, 8'h00);
    n_start = 0; n_abort = 0;
    reg_wr(2'd0, 64'h3, 8'hFE);
    idle(11);
    gcd_done = 1'b1;
    idle(2);
    check("done_irq_latency", 64'(irq), 64'h0);
    idle(1);
    check("done_irq", 64'(irq), 64'h1);
    reg_rd(2'd1, d);
    check("done_status", d, 64'h2);
    reg_rd(2'd2, d);
    check("done_cycles", d, 64'd10);
    check("done_start_pulses", 64'(n_start), 64'd1);
    check("done_no_abort", 64'(n_abort), 64'd0);
    gcd_done = 1'b0;
    reg_wr(2'd1, 64'h2, 8'hFE);
    idle(1);
    check("w1c_irq", 64'(irq), 64'h0);
    reg_rd(2'd1, d);
    check("w1c_status", d, 64'h0);

    // Timeout with LIMIT=5.
    reg_wr(2'd3, 64'd5, 8'h00);
    n_start = 0; n_abort = 0;
    reg_wr(2'd0, 64'h3, 8'hFE);
    reg_rd(2'd1, d);
    check("to_busy", d, 64'h1);
    idle(10);
    check("to_abort_pulses", 64'(n_abort), 64'd1);
    reg_rd(2'd1, d);
    check("to_status", d, 64'h4);
    reg_rd(2'd2, d);
    check("to_cycles", d, 64'd5);
    check("to_irq", 64'(irq), 64'h1);

    // Software abort; second START while busy ignored.
    reg_wr(2'd3, 64'd100, 8'h00);
    n_start = 0; n_abort = 0;
    reg_wr(2'd0, 64'h3, 8'hFE);
    idle(4);
    reg_wr(2'd0, 64'h3, 8'hFE);
    reg_wr(2'd0, 64'h6, 8'hFE);
    idle(3);
    check("ab_start_pulses", 64'(n_start), 64'd1);
    check("ab_abort_pulses", 64'(n_abort), 64'd1);
    reg_rd(2'd1, d);
    check("ab_status", d, 64'h0);
    reg_rd(2'd2, d);
    check("ab_cycles", d, 64'd5);
    reg_wr(2'd0, 64'h6, 8'hFE);
    idle(2);
    check("ab_idle_ignored", 64'(n_abort), 64'd1);

    // DONE edge and timeout in the same cycle: DONE wins.
    reg_wr(2'd3, 64'd4, 8'h00);
    n_start = 0; n_abort = 0;
    reg_wr(2'd0, 64'h3, 8'hFE);
    idle(4);
    gcd_done = 1'b1;
    idle(3);
    reg_rd(2'd1, d);
    check("col_status", d, 64'h2);
    reg_rd(2'd2, d);
    check("col_cycles", d, 64'd3);
    check("col_no_abort", 64'(n_abort), 64'd0);

    // DONE held high across a new job, then reset mid-run.
    reg_wr(2'd3, 64'd0, 8'h00);
    n_start = 0; n_abort = 0;
    reg_wr(2'd0, 64'h3, 8'hFE);
    idle(8);
    reg_rd(2'd1, d);
    check("stale_done_busy", d, 64'h1);
    idle(2);
    check("stale_done_irq", 64'(irq), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdata", rdata, 64'h0);
    check("arst_start", 64'(gcd_start), 64'h0);
    check("arst_abort", 64'(gcd_abort), 64'h0);
    check("arst_irq", 64'(irq), 64'h0);
    gcd_done = 1'b0;
    idle(3);
    check("arst_no_abort", 64'(n_abort), 64'd0);
    rst_n = 1'b1;
    idle(1);
    reg_rd(2'd0, d);
    check("post_ctrl", d, 64'h0);
    reg_rd(2'd1, d);
    check("post_status", d, 64'h0);
    reg_rd(2'd2, d);
    check("post_cycles", d, 64'h0);
    reg_rd(2'd3, d);
    check("post_limit", d, 64'h000F_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
